mmio_switch_port: RTL and testbench

Memory-mapped input peripheral that sits upstream of the CPU's read_data bus, alongside RAM.
- Synchronizes and debounces the 8 slide switches.
- Records which bits changed since software last looked.
- Returns either value to the CPU on an MREAD to its address window.
- Replaces the direct combinational SW-to-bus path with a registered, glitch-free source plus a sticky change-status register.

---
 rtl/mmio_switch_port.sv | 142 ++++++++++++++
 tb/tb_mmio_switch_port.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_switch_port.sv
// rtl/mmio_switch_port.sv - debounced slide-switch MMIO port with sticky change status
// Optional mask register and interrupt output are built when SWITCH_PORT_IRQ_EN is defined.
module mmio_switch_port #(
    parameter logic [8:0] BASE_ADDR       = 9'h140,
    parameter int         DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] wr_data,
    input  logic [7:0]  sw_raw,
    output logic        rd_drive,
    output logic [15:0] rd_data,
    output logic        irq
);
    localparam int            CW          = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [8:0]    ADDR_DATA   = BASE_ADDR;
    localparam logic [8:0]    ADDR_STATUS = BASE_ADDR + 9'd1;
    localparam logic [8:0]    ADDR_MASK   = BASE_ADDR + 9'd2;
    localparam logic [1:0]    CMD_READ    = 2'b11;
    localparam logic [1:0]    CMD_WRITE   = 2'b01;

    logic [7:0]    s1;
    logic [7:0]    s2;
    logic [7:0]    stable;
    logic [7:0]    change;
    logic [7:0]    chg_set;
    logic [7:0]    chg_clr;
    logic [7:0]    status_snap;
    logic [7:0]    status_view;
    logic [7:0]    mask_q;
    logic [CW-1:0] cnt [8];
    logic          in_window;
    logic          rd_sel;
    logic          wr_sel;
    logic          rd_status;
    logic          rd_sel_d;
    logic          rd_first;
    logic          unused_wr_hi;

    assign unused_wr_hi = ^wr_data[15:8];

    assign in_window = (mem_addr == ADDR_DATA) || (mem_addr == ADDR_STATUS) ||
                       (mem_addr == ADDR_MASK);
    assign rd_sel    = (mem_cmd == CMD_READ)  && in_window;
    assign wr_sel    = (mem_cmd == CMD_WRITE) && in_window;
    assign rd_status = rd_sel && (mem_addr == ADDR_STATUS);
    assign rd_first  = rd_status && !rd_sel_d;

    // A bit is accepted once its synchronized value has differed for DEBOUNCE_CYCLES edges.
    always_comb begin
        chg_set = '0;
        for (int i = 0; i < 8; i++) begin
            chg_set[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= sw_raw;
            s2     <= s1;
            stable <= stable ^ chg_set;
            for (int i = 0; i < 8; i++) begin
                if ((s2[i] == stable[i]) || chg_set[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        chg_clr = '0;
        if (rd_first) begin
            chg_clr = 8'hFF;
        end
        if (wr_sel && (mem_addr == ADDR_STATUS)) begin
            chg_clr = chg_clr | wr_data[7:0];
        end
    end

    // The snapshot lets a multi-cycle STATUS read keep returning the pre-clear value.
    always_ff @(posedge clk) begin
        if (reset) begin
            change      <= '0;
            rd_sel_d    <= 1'b0;
            status_snap <= '0;
        end else begin
            change   <= (change & ~chg_clr) | chg_set;
            rd_sel_d <= rd_status;
            if (rd_first) begin
                status_snap <= change;
            end
        end
    end

    assign status_view = rd_sel_d ? status_snap : change;

`ifdef SWITCH_PORT_IRQ_EN
    logic [7:0] mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr_sel && (mem_addr == ADDR_MASK)) begin
                mask <= wr_data[7:0];
            end
            irq <= |(change & mask);
        end
    end

    assign mask_q = mask;
`else
    assign mask_q = '0;
    assign irq    = 1'b0;
`endif

    assign rd_drive = rd_sel;

    always_comb begin
        rd_data = 16'h0000;
        if (rd_sel) begin
            case (mem_addr)
                ADDR_DATA:   rd_data = {8'h00, stable};
                ADDR_STATUS: rd_data = {|status_view, 7'b000_0000, status_view};
                default:     rd_data = {8'h00, mask_q};
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_switch_port.sv
// tb/tb_mmio_switch_port.sv - directed self-checking bench for mmio_switch_port
// Exercises the mask/irq path when compiled with SWITCH_PORT_IRQ_EN defined.
module tb_mmio_switch_port;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] wr_data;
    logic [7:0]  sw_raw;
    logic        rd_drive;
    logic [15:0] rd_data;
    logic        irq;

    int passed = 0;
    int total  = 0;

    mmio_switch_port #(
        .BASE_ADDR       (9'h140),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_cmd  (mem_cmd),
        .mem_addr (mem_addr),
        .wr_data  (wr_data),
        .sw_raw   (sw_raw),
        .rd_drive (rd_drive),
        .rd_data  (rd_data),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rd(input logic [8:0] a);
        mem_cmd  = 2'b11;
        mem_addr = a;
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        mem_cmd  = 2'b01;
        mem_addr = a;
        wr_data  = d;
        #1;
    endtask

    task automatic idle();
        mem_cmd  = 2'b00;
        mem_addr = 9'h000;
        wr_data  = 16'h0000;
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        sw_raw = 8'hFF;
        idle();

        // reset with switches high
        step(1);
        check("rst_drive", {15'b0, rd_drive}, 16'h0000);
        check("rst_data", rd_data, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        step(1);
        rd(9'h140);
        check("rst_read", rd_data, 16'h0000);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check("rel_wait", rd_data, 16'h0000);
        end
        step(1);
        check("rel_data", rd_data, 16'h00FF);
        rd(9'h141);
        check("rel_status", rd_data, 16'h80FF);
        step(1);
        idle();

        // reset again with switches low
        sw_raw = 8'h00;
        reset  = 1'b1;
        step(2);
        reset = 1'b0;
        rd(9'h141);
        check("rst2_status", rd_data, 16'h0000);
        rd(9'h140);
        check("rst2_data", rd_data, 16'h0000);
        idle();
        step(8);

        // reset mid-debounce drops the pending change
        sw_raw = 8'h02;
        step(4);
        reset = 1'b1;
        step(1);
        reset  = 1'b0;
        sw_raw = 8'h00;
        step(8);
        rd(9'h140);
        check("midrst_data", rd_data, 16'h0000);
        rd(9'h141);
        check("midrst_status", rd_data, 16'h0000);
        step(1);
        idle();
        step(1);

        // bounce on bit 3
        rd(9'h140);
        for (int i = 0; i < 20; i++) begin
            sw_raw[3] = (((i / 2) % 2) == 0);
            step(1);
            check("bounce_hold", rd_data, 16'h0000);
        end
        sw_raw[3] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check("bounce_wait", rd_data, 16'h0000);
        end
        step(1);
        check("bounce_done", rd_data, 16'h0008);
        idle();
        step(1);

        // read-to-clear over a 3-cycle access
        rd(9'h141);
        check("rc_cyc1", rd_data, 16'h8008);
        step(1);
        check("rc_cyc2", rd_data, 16'h8008);
        step(1);
        check("rc_cyc3", rd_data, 16'h8008);
        idle();
        step(1);
        rd(9'h141);
        check("rc_after", rd_data, 16'h0000);
        step(1);
        idle();
        step(1);

        // set wins over read-clear on the same edge
        sw_raw = 8'h28;
        step(5);
        rd(9'h141);
        check("sw_first", rd_data, 16'h0000);
        step(1);
        check("sw_snap", rd_data, 16'h0000);
        idle();
        step(1);
        rd(9'h140);
        check("sw_data", rd_data, 16'h0028);
        rd(9'h141);
        check("sw_status", rd_data, 16'h8020);
        step(1);
        idle();
        step(1);

        // write-1-to-clear, DATA writes ignored, decode
        sw_raw = 8'hA9;
        step(6);
        rd(9'h140);
        check("w1c_data", rd_data, 16'h00A9);
        wr(9'h141, 16'hFF01);
        step(1);
        wr(9'h140, 16'hFFFF);
        check("wr_nodrive", {15'b0, rd_drive}, 16'h0000);
        step(1);
        rd(9'h140);
        check("wr_data_ign", rd_data, 16'h00A9);
        rd(9'h141);
        check("w1c_status", rd_data, 16'h8080);
        step(1);
        idle();
        step(1);
        rd(9'h100);
        check("led_drive", {15'b0, rd_drive}, 16'h0000);
        check("led_data", rd_data, 16'h0000);
        rd(9'h042);
        check("ram_drive", {15'b0, rd_drive}, 16'h0000);
        check("ram_data", rd_data, 16'h0000);
        rd(9'h143);
        check("above_drive", {15'b0, rd_drive}, 16'h0000);
        rd(9'h13F);
        check("below_drive", {15'b0, rd_drive}, 16'h0000);
        idle();

`ifdef SWITCH_PORT_IRQ_EN
        wr(9'h142, 16'h0080);
        step(1);
        rd(9'h142);
        check("mask_read", rd_data, 16'h0080);
        check("irq_idle", {15'b0, irq}, 16'h0000);
        idle();
        sw_raw = 8'h29;
        step(6);
        check("irq_pre", {15'b0, irq}, 16'h0000);
        rd(9'h140);
        check("irq_data", rd_data, 16'h0029);
        idle();
        step(1);
        check("irq_rise", {15'b0, irq}, 16'h0001);
        wr(9'h141, 16'h0080);
        step(1);
        check("irq_lag", {15'b0, irq}, 16'h0001);
        idle();
        step(1);
        check("irq_fall", {15'b0, irq}, 16'h0000);
        sw_raw = 8'h28;
        step(8);
        check("irq_masked", {15'b0, irq}, 16'h0000);
        rd(9'h141);
        check("irq_status", rd_data, 16'h8001);
        step(1);
        idle();
        step(1);
`else
        rd(9'h142);
        check("mask_drive", {15'b0, rd_drive}, 16'h0001);
        check("mask_zero", rd_data, 16'h0000);
        wr(9'h142, 16'h00FF);
        step(1);
        rd(9'h142);
        check("mask_wr_ign", rd_data, 16'h0000);
        idle();
        sw_raw = 8'h29;
        step(8);
        check("irq_tied", {15'b0, irq}, 16'h0000);
        rd(9'h141);
        check("noirq_status", rd_data, 16'h8080);
        step(1);
        idle();
        step(1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
